// File: rtl/quantize_stream_if.sv
// Coefficient-in / level-out stream bundle for quantize_stream.
// The slave modport is the quantizer's view; the master modport is the view of the surrounding pipeline.
interface quantize_stream_if #(
   parameter int IW    = 16,
   parameter int LANES = 4
);
   logic                  in_valid;
   logic                  in_ready;
   logic [IW*LANES-1:0]   in_data;
   logic                  out_valid;
   logic                  out_ready;
   logic [16*LANES-1:0]   out_level;
   logic [16*LANES-1:0]   out_rout;
   logic                  out_nz;
   logic                  out_last;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_level, out_rout, out_nz, out_last
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_level, out_rout, out_nz, out_last
   );
endinterface

// File: rtl/quantize_stream.sv
// Streaming 4x4 coefficient quantizer with a ping-pong block buffer and a drain FSM.
// Defining QUANT_ZIGZAG_EN emits out_level in zigzag scan order; otherwise raster order is used.
module quantize_stream #(
   parameter int IW        = 16,
   parameter int LANES     = 4,
   parameter int QBITS     = 17,
   parameter int MAX_LEVEL = 2047
) (
   input  logic           clk,
   input  logic           rst_n,
   quantize_stream_if.slave strm,
   input  logic [255:0]   q,
   input  logic [255:0]   iq,
   input  logic [511:0]   bias,
   input  logic [511:0]   zthresh,
   input  logic [255:0]   sharpen
);
   localparam int BPB = 16 / LANES;
   localparam int BW  = (BPB > 1) ? $clog2(BPB) : 1;
   localparam int SW  = IW + 18;
   localparam logic [BW-1:0] LAST_BEAT = BW'(BPB - 1);
   localparam logic [0:0] ST_IDLE = 1'b0;
   localparam logic [0:0] ST_SEND = 1'b1;

   logic            alive;
   logic [1:0]      full, full_nxt;
   logic            in_bank, rd_bank;
   logic [BW-1:0]   in_beat, out_beat;
   logic [0:0]      state;
   logic            accept, out_fire, last_write, drain_done, any_nz;

   logic [IW*LANES-1:0] c0;
   logic [BW-1:0]   beat0, beat1;
   logic            v0, v1, bank0, bank1;
   logic [15:0]     lvl_c [LANES];
   logic            neg_c [LANES];
   logic            keep_c [LANES];
   logic [15:0]     lvl1 [LANES];
   logic            neg1 [LANES];
   logic            keep1 [LANES];
   logic [3:0]      p2 [LANES];
   logic [15:0]     lev2 [LANES];
   logic [15:0]     rout2 [LANES];

   logic [15:0]     level_mem [2][16];
   logic [15:0]     rout_mem [2][16];
   logic            nz_mem [2];

   function automatic logic [3:0] zigzag(input logic [3:0] s);
      case (s)
         4'd0: zigzag = 4'd0;   4'd1: zigzag = 4'd1;   4'd2: zigzag = 4'd4;   4'd3: zigzag = 4'd8;
         4'd4: zigzag = 4'd5;   4'd5: zigzag = 4'd2;   4'd6: zigzag = 4'd3;   4'd7: zigzag = 4'd6;
         4'd8: zigzag = 4'd9;   4'd9: zigzag = 4'd12;  4'd10: zigzag = 4'd13; 4'd11: zigzag = 4'd10;
         4'd12: zigzag = 4'd7;  4'd13: zigzag = 4'd11; 4'd14: zigzag = 4'd14; default: zigzag = 4'd15;
      endcase
   endfunction

   // Readiness tracks the bank the next accepted beat will land in, not the bank still being written.
   assign strm.in_ready = alive & ~full[in_bank];
   assign accept        = strm.in_valid & strm.in_ready;
   assign strm.out_valid = (state == ST_SEND);
   assign out_fire      = strm.out_valid & strm.out_ready;
   assign last_write    = v1 && (beat1 == LAST_BEAT);
   assign drain_done    = out_fire && (out_beat == LAST_BEAT);
   assign strm.out_last = strm.out_valid && (out_beat == LAST_BEAT);
   assign strm.out_nz   = strm.out_valid & nz_mem[rd_bank];

   for (genvar j = 0; j < LANES; j++) begin : g_lane
      logic [3:0]          p0, s;
      logic [3:0]          li;
      logic signed [IW-1:0] c;
      logic [IW-1:0]       a;
      logic [IW:0]         mag;
      logic [SW-1:0]       sum, shr;

      assign p0  = 4'(int'(beat0) * LANES + j);
      assign c   = c0[j*IW +: IW];
      assign a   = c[IW-1] ? IW'(-c) : IW'(c);
      assign mag = {1'b0, a} + (IW+1)'(sharpen[16*p0 +: 16]);
      assign sum = SW'(mag) * SW'(iq[16*p0 +: 16]) + SW'(bias[32*p0 +: 32]);
      assign shr = sum >> QBITS;
      assign lvl_c[j]  = (shr > SW'(MAX_LEVEL)) ? 16'(MAX_LEVEL) : shr[15:0];
      assign keep_c[j] = 64'(mag) > 64'(zthresh[32*p0 +: 32]);
      assign neg_c[j]  = c[IW-1];

      assign p2[j]    = 4'(int'(beat1) * LANES + j);
      assign lev2[j]  = keep1[j] ? (neg1[j] ? 16'(-lvl1[j]) : lvl1[j]) : 16'd0;
      assign rout2[j] = 16'(lev2[j] * q[16*p2[j] +: 16]);

      assign s = 4'(int'(out_beat) * LANES + j);
`ifdef QUANT_ZIGZAG_EN
      assign li = zigzag(s);
`else
      assign li = s;
`endif
      assign strm.out_level[16*j +: 16] = strm.out_valid ? level_mem[rd_bank][li] : 16'd0;
      assign strm.out_rout[16*j +: 16]  = strm.out_valid ? rout_mem[rd_bank][s] : 16'd0;
   end

   always_comb begin
      any_nz = 1'b0;
      for (int j = 0; j < LANES; j++) any_nz = any_nz | (lev2[j] != 16'd0);
   end

   always_comb begin
      full_nxt = full;
      if (last_write) full_nxt[bank1] = 1'b1;
      if (drain_done) full_nxt[rd_bank] = 1'b0;
   end

   // Input capture, lvl stage and fill-side bookkeeping; every beat carries its bank tag down the pipe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         alive   <= 1'b0;
         in_bank <= 1'b0;
         in_beat <= '0;
         v0      <= 1'b0;
         v1      <= 1'b0;
         c0      <= '0;
         beat0   <= '0;
         beat1   <= '0;
         bank0   <= 1'b0;
         bank1   <= 1'b0;
         for (int j = 0; j < LANES; j++) begin
            lvl1[j]  <= 16'd0;
            neg1[j]  <= 1'b0;
            keep1[j] <= 1'b0;
         end
      end else begin
         alive <= 1'b1;
         v0    <= accept;
         if (accept) begin
            c0    <= strm.in_data;
            beat0 <= in_beat;
            bank0 <= in_bank;
            if (in_beat == LAST_BEAT) begin
               in_beat <= '0;
               in_bank <= ~in_bank;
            end else begin
               in_beat <= in_beat + 1'b1;
            end
         end
         v1    <= v0;
         beat1 <= beat0;
         bank1 <= bank0;
         for (int j = 0; j < LANES; j++) begin
            lvl1[j]  <= lvl_c[j];
            neg1[j]  <= neg_c[j];
            keep1[j] <= keep_c[j];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (v1) begin
         for (int j = 0; j < LANES; j++) begin
            level_mem[bank1][p2[j]] <= lev2[j];
            rout_mem[bank1][p2[j]]  <= rout2[j];
         end
         nz_mem[bank1] <= (beat1 == '0) ? any_nz : (nz_mem[bank1] | any_nz);
      end
   end

   // Banks fill and drain in strict alternation, so the oldest full bank is always rd_bank.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         full     <= 2'b00;
         state    <= ST_IDLE;
         rd_bank  <= 1'b0;
         out_beat <= '0;
      end else begin
         full <= full_nxt;
         case (state)
            ST_IDLE: if (full_nxt[rd_bank]) state <= ST_SEND;
            default: begin
               if (out_fire) begin
                  if (out_beat == LAST_BEAT) begin
                     out_beat <= '0;
                     rd_bank  <= ~rd_bank;
                     state    <= full_nxt[~rd_bank] ? ST_SEND : ST_IDLE;
                  end else begin
                     out_beat <= out_beat + 1'b1;
                  end
               end
            end
         endcase
      end
   end
endmodule
